// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (shift-add / restoring, one bit per cycle).
// Optional macro MULDIV_EARLY_OUT_EN: single-cycle completion for zero-operand multiply/divide.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_rs1,
  input  logic [XLEN-1:0] i_req_rs2,
  input  logic            i_kill,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_data,
  output logic            o_busy
);
  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned AW = 2 * XLEN;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_opnd;
  logic [AW-1:0]   r_acc;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic            r_busy;
  logic [XLEN-1:0] r_resp_data;

  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_special_data;

  // Operand decode and magnitude extraction for the accept cycle
  assign w_is_div = i_req_funct3[2];
  assign w_sgn_a  = w_is_div ? ~i_req_funct3[0] : (i_req_funct3[1:0] != 2'b11);
  assign w_sgn_b  = w_is_div ? ~i_req_funct3[0] : ~i_req_funct3[1];
  assign w_neg_a  = w_sgn_a & i_req_rs1[XLEN-1];
  assign w_neg_b  = w_sgn_b & i_req_rs2[XLEN-1];
  assign w_abs_a  = w_neg_a ? (~i_req_rs1 + XLEN'(1)) : i_req_rs1;
  assign w_abs_b  = w_neg_b ? (~i_req_rs2 + XLEN'(1)) : i_req_rs2;
  assign w_div0   = w_is_div && (i_req_rs2 == '0);
  assign w_ovf    = w_is_div && !i_req_funct3[0] && (i_req_rs1 == MIN_NEG) && (i_req_rs2 == '1);

  // Results known at accept time, bypassing the iteration
  always_comb begin
    w_special      = 1'b0;
    w_special_data = '0;
    if (w_div0) begin
      w_special      = 1'b1;
      w_special_data = i_req_funct3[1] ? i_req_rs1 : '1;
    end else if (w_ovf) begin
      w_special      = 1'b1;
      w_special_data = i_req_funct3[1] ? '0 : MIN_NEG;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (w_is_div ? (i_req_rs1 == '0) : ((i_req_rs1 == '0) || (i_req_rs2 == '0))) begin
      w_special      = 1'b1;
      w_special_data = '0;
    end
`else
    else begin
      w_special      = 1'b0;
    end
`endif
  end

  logic [XLEN:0]   w_mul_sum;
  logic [AW-1:0]   w_mul_next;
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_qbit;
  logic [AW-1:0]   w_div_next;

  // Accumulator holds {high/remainder, low/quotient}; low half shifts out the multiplier or dividend
  assign w_mul_sum  = {1'b0, r_acc[AW-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_shift    = r_acc[AW-1:XLEN-1];
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_qbit     = ~w_diff[XLEN];
  assign w_div_next = {(w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_qbit};

  logic [AW-1:0]   w_prod;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_data;

  // Sign correction and result selection
  always_comb begin
    w_prod = r_neg_res ? (~r_acc + AW'(1)) : r_acc;
    w_quo  = r_neg_res ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    w_rem  = r_neg_rem ? (~r_acc[AW-1:XLEN] + XLEN'(1)) : r_acc[AW-1:XLEN];
    if (r_f3[2]) w_fix_data = r_f3[1] ? w_rem : w_quo;
    else         w_fix_data = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[AW-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_f3         <= '0;
      r_opnd       <= '0;
      r_acc        <= '0;
      r_neg_res    <= 1'b0;
      r_neg_rem    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && !i_kill) begin
            r_f3        <= i_req_funct3;
            r_neg_res   <= w_neg_a ^ w_neg_b;
            r_neg_rem   <= w_neg_a;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_special) begin
              r_resp_data  <= w_special_data;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_cnt   <= CNT_INIT;
              r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
              r_acc   <= {XLEN'(0), (w_is_div ? w_abs_a : w_abs_b)};
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_kill) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_acc <= r_f3[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (i_kill) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_resp_data  <= w_fix_data;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          // kill takes priority over the response handshake
          if (i_kill || i_resp_ready) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_busy       = r_busy;
endmodule
